// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, fault codes, LSU states
// and the request fault classifier.
package rv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] FLT_NONE     = 2'd0;
   localparam logic [1:0] FLT_MISALIGN = 2'd1;
   localparam logic [1:0] FLT_ACCESS   = 2'd2;
   localparam logic [1:0] FLT_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_RESP      = 2'd2
   } lsu_state_e;

   // Priority: illegal funct3, then misalignment, then region miss.
   function automatic logic [1:0] lsu_fault(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] offset,
                                            input logic       tag_ok);
      logic illegal;
      logic misalign;
      if (we) begin
         illegal = (funct3 > F3_W);
      end else begin
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      case (funct3)
         F3_H, F3_HU: misalign = offset[0];
         F3_W:        misalign = (offset != 2'b00);
         default:     misalign = 1'b0;
      endcase
      if (illegal) begin
         return FLT_ILLEGAL;
      end else if (misalign) begin
         return FLT_MISALIGN;
      end else if (!tag_ok) begin
         return FLT_ACCESS;
      end else begin
         return FLT_NONE;
      end
   endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// Request/response handshake between the memory stage (master) and the LSU (slave).
interface rv_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/rv_lsu_fmt.sv
// Load-lane extraction and sign/zero extension of a 32-bit memory word.
module rv_lsu_fmt
   import rv_pkg::*;
(
   input  logic [31:0] q_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   always_comb begin
      byte_s = q_i[8*offset_i +: 8];
      half_s = offset_i[1] ? q_i[31:16] : q_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   data_o = {24'h00_0000, byte_s};
         F3_H:    data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   data_o = {16'h0000, half_s};
         F3_W:    data_o = q_i;
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/rv_lsu.sv
// RV32I load/store unit: one request at a time to a 1-cycle synchronous dmem,
// returning formatted load data or a fault code as a registered response pulse.
module rv_lsu
   import rv_pkg::*;
#(
   parameter logic [8:0]  REGION_TAG = 9'h001,
   parameter int unsigned TAG_LSB    = 23
) (
   input  logic        clk,
   input  logic        rst,
   rv_lsu_if.slave     bus,
   output logic        dmem_en,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_d,
   output logic [3:0]  dmem_we,
   input  logic [31:0] dmem_q
);

   lsu_state_e  state_q, state_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_fault_q, rsp_fault_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic        accept_s;
   logic        tag_ok_s;
   logic [1:0]  fault_s;
   logic [31:0] fmt_word_s;

   assign tag_ok_s      = (bus.req_addr[TAG_LSB +: 9] == REGION_TAG);
   assign fault_s       = lsu_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0], tag_ok_s);
   assign bus.req_ready = (state_q == ST_IDLE) && !rst;
   assign accept_s      = bus.req_valid && bus.req_ready;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_fault = rsp_fault_q;

   rv_lsu_fmt u_fmt (
      .q_i      (dmem_q),
      .funct3_i (f3_q),
      .offset_i (off_q),
      .data_o   (fmt_word_s)
   );

   // State and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_fault_q <= FLT_NONE;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
      end
   end

   // Next state; stores and faults answer next cycle, loads wait out dmem latency.
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_fault_d = rsp_fault_q;
      f3_d        = f3_q;
      off_d       = off_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (bus.req_we || (fault_s != FLT_NONE))) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 32'h0000_0000;
               rsp_fault_d = fault_s;
            end else if (accept_s) begin
               state_d = ST_LOAD_WAIT;
               f3_d    = bus.req_funct3;
               off_d   = bus.req_addr[1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_WAIT: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fmt_word_s;
            rsp_fault_d = FLT_NONE;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Combinational dmem drive in the accept cycle of a fault-free request.
   always_comb begin
      dmem_en   = 1'b0;
      dmem_we   = 4'b0000;
      dmem_d    = 32'h0000_0000;
      dmem_addr = {bus.req_addr[31:2], 2'b00};
      if (accept_s && (fault_s == FLT_NONE)) begin
         dmem_en = 1'b1;
         if (bus.req_we) begin
            case (bus.req_funct3)
               F3_B: begin
                  dmem_we = 4'b0001 << bus.req_addr[1:0];
                  dmem_d  = {4{bus.req_wdata[7:0]}};
               end
               F3_H: begin
                  dmem_we = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                  dmem_d  = {2{bus.req_wdata[15:0]}};
               end
               F3_W: begin
                  dmem_we = 4'b1111;
                  dmem_d  = bus.req_wdata;
               end
               default: begin
                  dmem_we = 4'b0000;
                  dmem_d  = 32'h0000_0000;
               end
            endcase
         end else begin
            dmem_we = 4'b0000;
            dmem_d  = 32'h0000_0000;
         end
      end else begin
         dmem_en = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: directed test-plan sequence plus random traffic
// checked against a byte-array memory model.
module tb_rv_lsu;
   import rv_pkg::*;

   logic        clk;
   logic        rst;
   logic        dmem_en;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_d;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_q;

   rv_lsu_if bus ();

   rv_lsu dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dmem_en   (dmem_en),
      .dmem_addr (dmem_addr),
      .dmem_d    (dmem_d),
      .dmem_we   (dmem_we),
      .dmem_q    (dmem_q)
   );

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  fault;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] dmem_mem [0:63];
   logic [7:0]  ref_mem  [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous data memory with per-byte write enables.
   always @(posedge clk) begin
      if (dmem_en === 1'b1) begin
         dmem_q <= dmem_mem[dmem_addr[7:2]];
         for (int i = 0; i < 4; i++) begin
            if (dmem_we[i]) dmem_mem[dmem_addr[7:2]][8*i +: 8] <= dmem_d[8*i +: 8];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int access_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [1:0] ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      bit legal;
      legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (!legal) return 2'd3;
      if ((addr % access_size(f3)) != 0) return 2'd1;
      if (addr[31:23] != 9'h001) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] val;
      int          size;
      size = access_size(f3);
      val  = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(ref_mem[(addr[7:0] + i) % 256]) << (8 * i));
      if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      return val;
   endfunction

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold, input bit expect_rsp,
                        output int acc_cyc, output int waited);
      logic [1:0]  flt;
      logic [3:0]  exp_we;
      logic [31:0] exp_d;
      int          size;
      int          off;
      exp_t        e;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      acc_cyc = cyc;
      if (!bus.req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: req_ready stuck at 0, expected 1 within 20 cycles");
         bus.req_valid = 1'b0;
         return;
      end
      flt    = ref_fault(we, f3, addr);
      size   = access_size(f3);
      off    = int'(addr[1:0]);
      exp_we = 4'b0000;
      exp_d  = 32'h0;
      if (flt == 2'd0 && we) begin
         for (int i = 0; i < 4; i++) begin
            exp_we[i]         = (i >= off) && (i < off + size);
            exp_d[8*i +: 8]   = wdata[8*(i % size) +: 8];
         end
      end
      check("dmem_en", {31'h0, dmem_en}, {31'h0, (flt == 2'd0)});
      check("dmem_we", {28'h0, dmem_we}, {28'h0, exp_we});
      check("dmem_d", dmem_d, exp_d);
      if (flt == 2'd0) check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      if (we || flt != 2'd0) begin
         e.rdata = 32'h0;
         e.cyc   = acc_cyc + 1;
      end else begin
         e.rdata = ref_load(f3, addr);
         e.cyc   = acc_cyc + 2;
      end
      e.fault = flt;
      if (we && flt == 2'd0) begin
         for (int i = 0; i < size; i++) ref_mem[addr[7:0] + i] = wdata[8*i +: 8];
      end
      if (expect_rsp) exp_q.push_back(e);
      @(posedge clk);
      if (!hold) begin
         #1 bus.req_valid = 1'b0;
      end
   endtask

   // Response monitor: pops the scoreboard on every rsp_valid pulse.
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with rdata 0x%08h, expected no response", bus.rsp_rdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
            check("rsp_fault", {30'h0, bus.rsp_fault}, {30'h0, mon_e.fault});
            check("rsp_cycle", cyc, mon_e.cyc);
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_rsp: no rsp_valid, expected one at cycle %0d", mon_e.cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, w;
      for (int i = 0; i < 64; i++)  dmem_mem[i] = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[i]  = 8'h0;
      rst            = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h0080_0000;
      bus.req_wdata  = 32'h1111_1111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
      check("rst_dmem_en", {31'h0, dmem_en}, 32'h0);
      check("rst_dmem_we", {28'h0, dmem_we}, 32'h0);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("reset_rsp_fault", {30'h0, bus.rsp_fault}, 32'h0);

      // Directed test-plan sequence
      issue(1'b1, F3_W,  32'h0080_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, a0, w);
      issue(1'b0, F3_W,  32'h0080_0010, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b1, F3_B,  32'h0080_0013, 32'h0000_0080, 1'b0, 1'b1, a0, w);
      issue(1'b0, F3_B,  32'h0080_0013, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b0, F3_BU, 32'h0080_0013, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b0, F3_W,  32'h0080_0010, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b1, F3_H,  32'h0080_0012, 32'h0000_1234, 1'b0, 1'b1, a0, w);
      issue(1'b0, F3_W,  32'h0080_0010, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b0, F3_H,  32'h0080_0012, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b0, F3_HU, 32'h0080_0012, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b0, F3_W,  32'h0080_0002, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b1, F3_W,  32'h0100_0000, 32'h5555_5555, 1'b0, 1'b1, a0, w);
      issue(1'b0, 3'b011, 32'h0080_0000, 32'h0,        1'b0, 1'b1, a0, w);
      issue(1'b0, F3_H,  32'h0000_0001, 32'h0,         1'b0, 1'b1, a0, w);
      issue(1'b1, 3'b100, 32'h0080_0020, 32'h7777_7777, 1'b0, 1'b1, a0, w);

      // Back-to-back loads with req_valid held high
      issue(1'b0, F3_W,  32'h0080_0010, 32'h0, 1'b1, 1'b1, a0, w);
      issue(1'b0, F3_B,  32'h0080_0011, 32'h0, 1'b1, 1'b1, a1, w);
      check("b2b_wait1", w, 32'd2);
      issue(1'b0, F3_HU, 32'h0080_0010, 32'h0, 1'b0, 1'b1, a2, w);
      check("b2b_wait2", w, 32'd2);
      check("b2b_gap1", a1 - a0, 32'd3);
      check("b2b_gap2", a2 - a1, 32'd3);

      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra;
         if ($urandom_range(0, 7) == 0) ra = $urandom;
         else ra = 32'h0080_0000 | 32'($urandom_range(0, 255));
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
               1'($urandom_range(0, 1)), 1'b1, a0, w);
      end

      // Reset while a load is in LOAD_WAIT: response must be dropped
      issue(1'b0, F3_W, 32'h0080_0010, 32'h0, 1'b0, 1'b0, a0, w);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
      check("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("midrst_rsp_fault", {30'h0, bus.rsp_fault}, 32'h0);

      repeat (6) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Load/store unit between the rvcpu memory stage and the synchronous data memory (1-cycle registered read, per-byte write enables, decodes only the 0x0080_0000–0x00FF_FFFF region).
- Accepts one RV32I load/store request at a time over a valid/ready handshake.
- Drives the dmem port with byte-lane write enables and replicated store data.
- Waits out the read latency, then returns aligned and sign/zero-extended load data, or a fault code.

Parameters:
- REGION_TAG, 9'h001, required value of addr[31:23] for a legal dmem access.
- TAG_LSB, 23, bit position where the region tag starts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; consumer always ready.
- rsp_rdata  out  32  formatted load data; 0 for stores and faults.
- rsp_fault  out  2  0 none, 1 misaligned, 2 access fault, 3 illegal funct3.
- dmem_en  out  1  dmem enable.
- dmem_addr  out  32  dmem address (req_addr with bits [1:0] forced to 0).
- dmem_d  out  32  dmem write data.
- dmem_we  out  4  dmem byte write enables.
- dmem_q  in  32  dmem read data, valid the cycle after the enable.

Behaviour:
- Interface: one clock domain (clk); synchronous active-high reset (rst).
- States: IDLE, LOAD_WAIT, RESP.
  - req_ready = 1 only in IDLE and only when rst = 0.
- Accept cycle N (IDLE, req_valid = 1):
  - Fault check, priority illegal > misaligned > access.
    - illegal: load funct3 in {011, 110, 111}; store funct3 > 010.
    - misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
    - access: addr[31:23] != REGION_TAG.
  - dmem_en = accept & ~fault, driven combinationally in cycle N.
  - dmem_addr = {req_addr[31:2], 2'b00}.
  - dmem_we = 0 for loads.
- Store write enables and data:
  - SB: dmem_we = 4'b0001 << addr[1:0]; dmem_d = {4{wdata[7:0]}}.
  - SH: dmem_we = addr[1] ? 1100 : 0011; dmem_d = {2{wdata[15:0]}}.
  - SW: dmem_we = 1111; dmem_d = wdata.
- Outside an accepted, fault-free request: dmem_en = 0, dmem_we = 0, dmem_d = 0.
- Store or faulting request:
  - Next state RESP.
  - Cycle N+1: rsp_valid = 1, rsp_rdata = 0, rsp_fault = code.
  - Then IDLE.
  - Store latency is 1 cycle; a new request can be accepted in N+2.
- Fault-free load:
  - Registers funct3 and addr[1:0]; next state LOAD_WAIT.
  - Cycle N+1: the selected lane of dmem_q is formatted and registered into rsp_rdata.
    - Byte lane = q[8*off +: 8]; half lane = q[16*addr[1] +: 16].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Cycle N+2: rsp_valid = 1.
  - Load latency is 2 cycles.
- Response outputs are registered. rsp_rdata and rsp_fault hold their value until the next response and are only meaningful while rsp_valid = 1.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_fault 0, captured funct3/offset 0.
  - With rst = 1: req_ready 0, dmem_en 0, dmem_we 0.
- Reset mid-operation (LOAD_WAIT or RESP): the pending response is dropped and no rsp_valid is produced.
- req_valid while not ready: ignored; inputs need not be held stable.

Decomposition:
- Shared package rv_pkg holds:
  - funct3 constants: F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - fault code constants: FLT_NONE, FLT_MISALIGN, FLT_ACCESS, FLT_ILLEGAL.
  - LSU state enum.
- Sub-module rv_lsu_fmt: combinational load extraction and extension (inputs q, funct3, offset; output 32-bit word). It is reusable by a future MMIO path.

Test Plan:
- SW addr 0x0080_0010 data 0xDEADBEEF, then LW same address → dmem_we = 1111 in accept cycle; rsp after 1 cycle with fault 0; load rsp 2 cycles after accept with rdata 0xDEADBEEF.
- SB 0x0080_0013 data 0x80, then LB/LBU 0x0080_0013 → dmem_we = 1000, dmem_d = 0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080; other bytes unchanged (LW returns 0x80ADBEEF).
- SH 0x0080_0012 data 0x1234 over the above word, then LH/LHU 0x0080_0012 → we = 1100; LW gives 0x1234BEEF; LH gives 0x00001234.
- Faults:
  - LW 0x0080_0002 → fault 1.
  - SW 0x0100_0000 → fault 2.
  - funct3 = 011 load → fault 3.
  - LH 0x0000_0001 → fault 1 (priority over access).
  - All: dmem_en never 1, rsp_valid exactly 1 cycle after accept, rdata 0.
- Back-to-back: req_valid held high with 3 loads → req_ready deasserted in LOAD_WAIT/RESP; accepts occur every 3 cycles; responses in order.
- rst pulsed during LOAD_WAIT → no rsp_valid; next cycle after rst drops req_ready = 1; all response outputs 0.
